// File: rtl/psg_frame_sequencer.sv
// -----------------------------------------------------------------------------
// psg_frame_sequencer
//
// Frame sequencer for the PSG output path. A frame is FRAME_LAST+1 clocks long.
// The block:
//   * generates the select count for the channel summer and its channel mux;
//   * double-buffers the channel output-enable mask, so the active mask only
//     changes at a frame boundary (or at any edge while idle);
//   * captures the summed result once per frame, at the end of count 4, into a
//     one-entry valid/ready buffer, and flags a capture that finds the buffer
//     full as an overrun.
//
// Optional feature (macro PSG_SEQ_OVRCNT_EN):
//   defined   - ovr_cnt_o is a saturating 8-bit count of dropped samples,
//               cleared only by rst_i.
//   undefined - no counter is built and ovr_cnt_o is tied to 8'd0.
//
// Ports:
//   clk_i      in   1  master clock
//   rst_i      in   1  asynchronous active-high reset
//   en_i       in   1  run request, sampled at idle and at frame end
//   cfg_we_i   in   1  output-mask write strobe
//   cfg_dat_i  in   4  new output-enable mask (bit n = channel n)
//   cnt_o      out  8  select count to the summer
//   ch_sel_o   out  2  channel-mux select (always cnt_o[1:0])
//   outctrl_o  out  4  active output-enable mask
//   sum_i      in  22  summed output from the summer
//   smp_o      out 22  captured frame sample
//   smp_vld_o  out  1  sample valid
//   smp_rdy_i  in   1  downstream ready
//   ovr_o      out  1  sticky overrun flag
//   ovr_clr_i  in   1  clears ovr_o (a same-edge overrun wins)
//   ovr_cnt_o  out  8  overrun count
//   busy_o     out  1  high while running
// -----------------------------------------------------------------------------
module psg_frame_sequencer #(
   parameter logic [7:0] FRAME_LAST = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        cfg_we_i,
   input  logic [3:0]  cfg_dat_i,
   output logic [7:0]  cnt_o,
   output logic [1:0]  ch_sel_o,
   output logic [3:0]  outctrl_o,
   input  logic [21:0] sum_i,
   output logic [21:0] smp_o,
   output logic        smp_vld_o,
   input  logic        smp_rdy_i,
   output logic        ovr_o,
   input  logic        ovr_clr_i,
   output logic [7:0]  ovr_cnt_o,
   output logic        busy_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic [1:0]  ch_sel_r;
   logic        busy_r;
   logic [3:0]  pend_r;
   logic [3:0]  outctrl_r;
   logic [21:0] smp_r;
   logic        vld_r;
   logic        ovr_r;

   logic [3:0]  pend_nxt_s;
   logic [7:0]  cnt_inc_s;
   logic        run_s;
   logic        wrap_s;
   logic        capture_s;
   logic        xfer_s;
   logic        drop_s;

   // Frame-position decodes and the pending-mask next value (write bypass).
   always_comb begin
      pend_nxt_s = pend_r;
      if (cfg_we_i) begin
         pend_nxt_s = cfg_dat_i;
      end else begin
         pend_nxt_s = pend_r;
      end
      cnt_inc_s = cnt_r + 8'd1;
      run_s     = (state_r == ST_RUN);
      wrap_s    = run_s && (cnt_r == FRAME_LAST);
      // sum_i is final during count 4, so it is sampled on the edge ending it.
      capture_s = run_s && (cnt_r == 8'd4);
      xfer_s    = vld_r && smp_rdy_i;
      // A capture only loses data when the old sample is not leaving this edge.
      drop_s    = capture_s && vld_r && !smp_rdy_i;
   end

   // Run/idle FSM with the registered count, channel select and busy flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 8'd0;
         ch_sel_r <= 2'd0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // The entry cycle is already count 0 of the first frame.
               cnt_r    <= 8'd0;
               ch_sel_r <= 2'd0;
               if (en_i) begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (cnt_r == FRAME_LAST) begin
                  // en_i only matters here, so frames always complete.
                  cnt_r    <= 8'd0;
                  ch_sel_r <= 2'd0;
                  if (en_i) begin
                     state_r <= ST_RUN;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  cnt_r    <= cnt_inc_s;
                  ch_sel_r <= cnt_inc_s[1:0];
                  state_r  <= ST_RUN;
                  busy_r   <= 1'b1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= 8'd0;
               ch_sel_r <= 2'd0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   // Output-mask double buffer: active mask loads while idle and at frame wrap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_r    <= 4'd0;
         outctrl_r <= 4'd0;
      end else begin
         pend_r <= pend_nxt_s;
         if (!run_s || wrap_s) begin
            outctrl_r <= pend_nxt_s;
         end else begin
            outctrl_r <= outctrl_r;
         end
      end
   end

   // One-entry sample buffer and sticky overrun flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         smp_r <= 22'd0;
         vld_r <= 1'b0;
         ovr_r <= 1'b0;
      end else begin
         if (capture_s) begin
            if (!vld_r || smp_rdy_i) begin
               // Empty, or the old sample leaves on this same edge.
               smp_r <= sum_i;
               vld_r <= 1'b1;
            end else begin
               // Full and stalled: keep the old sample, drop the new one.
               smp_r <= smp_r;
               vld_r <= 1'b1;
            end
         end else if (xfer_s) begin
            vld_r <= 1'b0;
         end else begin
            vld_r <= vld_r;
         end

         if (drop_s) begin
            ovr_r <= 1'b1;
         end else if (ovr_clr_i) begin
            ovr_r <= 1'b0;
         end else begin
            ovr_r <= ovr_r;
         end
      end
   end

`ifdef PSG_SEQ_OVRCNT_EN
   logic [7:0] ovr_cnt_r;

   // Saturating dropped-sample counter; only rst_i clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovr_cnt_r <= 8'd0;
      end else if (drop_s && (ovr_cnt_r != 8'd255)) begin
         ovr_cnt_r <= ovr_cnt_r + 8'd1;
      end else begin
         ovr_cnt_r <= ovr_cnt_r;
      end
   end

   assign ovr_cnt_o = ovr_cnt_r;
`else
   assign ovr_cnt_o = 8'd0;
`endif

   assign cnt_o     = cnt_r;
   assign ch_sel_o  = ch_sel_r;
   assign busy_o    = busy_r;
   assign outctrl_o = outctrl_r;
   assign smp_o     = smp_r;
   assign smp_vld_o = vld_r;
   assign ovr_o     = ovr_r;

endmodule

// File: tb/tb_psg_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_psg_frame_sequencer
//
// Self-checking bench for psg_frame_sequencer. A behavioural model tracks the
// frame position as an integer, the held sample as a queue, and the overrun
// flag/count; every clock all outputs are compared against it. Stimulus is a
// directed sequence with randomized data and handshake phases. A short frame
// (FRAME_LAST = 63) keeps the overrun-saturation run short.
// -----------------------------------------------------------------------------
module tb_psg_frame_sequencer;

   localparam int FL = 63;

   logic        clk_i;
   logic        rst_i;
   logic        en_i;
   logic        cfg_we_i;
   logic [3:0]  cfg_dat_i;
   logic [7:0]  cnt_o;
   logic [1:0]  ch_sel_o;
   logic [3:0]  outctrl_o;
   logic [21:0] sum_i;
   logic [21:0] smp_o;
   logic        smp_vld_o;
   logic        smp_rdy_i;
   logic        ovr_o;
   logic        ovr_clr_i;
   logic [7:0]  ovr_cnt_o;
   logic        busy_o;

   int checks;
   int errors;

   // reference model state
   bit          m_busy;
   int          m_pos;
   logic [3:0]  m_pend;
   logic [3:0]  m_mask;
   logic [21:0] m_buf[$];
   logic [21:0] m_smp;
   bit          m_ovr;
   int          m_ovrcnt;

   psg_frame_sequencer #(.FRAME_LAST(8'(FL))) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .cfg_we_i  (cfg_we_i),
      .cfg_dat_i (cfg_dat_i),
      .cnt_o     (cnt_o),
      .ch_sel_o  (ch_sel_o),
      .outctrl_o (outctrl_o),
      .sum_i     (sum_i),
      .smp_o     (smp_o),
      .smp_vld_o (smp_vld_o),
      .smp_rdy_i (smp_rdy_i),
      .ovr_o     (ovr_o),
      .ovr_clr_i (ovr_clr_i),
      .ovr_cnt_o (ovr_cnt_o),
      .busy_o    (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_pos    = 0;
      m_pend   = 4'd0;
      m_mask   = 4'd0;
      m_buf.delete();
      m_smp    = 22'd0;
      m_ovr    = 1'b0;
      m_ovrcnt = 0;
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_step();
      logic [3:0]  np;
      logic [21:0] old;
      bit          cap;
      bit          fend;
      bit          dropped;
      np      = cfg_we_i ? cfg_dat_i : m_pend;
      cap     = m_busy && (m_pos == 4);
      fend    = m_busy && (m_pos == FL);
      dropped = 1'b0;
      if (cap) begin
         if (m_buf.size() == 0) begin
            m_buf.push_back(sum_i);
            m_smp = sum_i;
         end else if (smp_rdy_i) begin
            old = m_buf.pop_front();
            m_buf.push_back(sum_i);
            m_smp = sum_i;
         end else begin
            dropped = 1'b1;
         end
      end else if ((m_buf.size() != 0) && smp_rdy_i) begin
         old = m_buf.pop_front();
      end
      if (dropped) begin
         m_ovr = 1'b1;
         if (m_ovrcnt < 255) m_ovrcnt++;
      end else if (ovr_clr_i) begin
         m_ovr = 1'b0;
      end
      if (!m_busy || fend) m_mask = np;
      m_pend = np;
      if (!m_busy) begin
         m_pos  = 0;
         m_busy = en_i;
      end else if (fend) begin
         m_pos  = 0;
         m_busy = en_i;
      end else begin
         m_pos++;
      end
   endtask

   task automatic check_all();
      int exp_cnt;
      int exp_oc;
      exp_cnt = m_busy ? m_pos : 0;
`ifdef PSG_SEQ_OVRCNT_EN
      exp_oc = m_ovrcnt;
`else
      exp_oc = 0;
`endif
      chk("cnt",     32'(cnt_o),     32'(exp_cnt));
      chk("ch_sel",  32'(ch_sel_o),  32'(exp_cnt % 4));
      chk("busy",    32'(busy_o),    32'(m_busy));
      chk("outctrl", 32'(outctrl_o), 32'(m_mask));
      chk("smp",     32'(smp_o),     32'(m_smp));
      chk("vld",     32'(smp_vld_o), 32'(m_buf.size() != 0));
      chk("ovr",     32'(ovr_o),     32'(m_ovr));
      chk("ovr_cnt", 32'(ovr_cnt_o), 32'(exp_oc));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      check_all();
   endtask

   // Run until the model sits at position p of a running frame (bounded).
   task automatic go_to(input int p);
      for (int i = 0; i < 2 * (FL + 1) + 4; i++) begin
         if (m_busy && (m_pos == p)) break;
         tick();
      end
      chk("go_to_reached", 32'(m_busy && (m_pos == p)), 32'd1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_i     = 1'b1;
      en_i      = 1'b0;
      cfg_we_i  = 1'b0;
      cfg_dat_i = 4'd0;
      sum_i     = 22'd0;
      smp_rdy_i = 1'b0;
      ovr_clr_i = 1'b0;
      model_reset();

      // reset state
      #2;
      check_all();
      #1;
      rst_i = 1'b0;

      // basic capture: mask write in idle, then start
      cfg_we_i  = 1'b1;
      cfg_dat_i = 4'hF;
      tick();
      chk("mask_idle", 32'(outctrl_o), 32'h0000000F);
      cfg_we_i = 1'b0;
      en_i     = 1'b1;
      tick();
      sum_i = 22'h00ABCD;
      go_to(5);
      chk("basic_smp", 32'(smp_o), 32'h0000ABCD);
      chk("basic_vld", 32'(smp_vld_o), 32'd1);
      smp_rdy_i = 1'b1;
      tick();
      chk("basic_vld_drop", 32'(smp_vld_o), 32'd0);
      smp_rdy_i = 1'b0;

      // overrun over two frames
      go_to(0);
      sum_i = 22'h000111;
      go_to(10);
      sum_i = 22'h000222;
      go_to(0);
      go_to(10);
      chk("ovr_smp_kept", 32'(smp_o), 32'h00000111);
      chk("ovr_flag", 32'(ovr_o), 32'd1);
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      chk("ovr_cleared", 32'(ovr_o), 32'd0);

      // simultaneous transfer and capture
      go_to(0);
      sum_i = 22'h000333;
      go_to(4);
      smp_rdy_i = 1'b1;
      tick();
      smp_rdy_i = 1'b0;
      chk("simul_smp", 32'(smp_o), 32'h00000333);
      chk("simul_vld", 32'(smp_vld_o), 32'd1);
      chk("simul_ovr", 32'(ovr_o), 32'd0);

      // clear and overrun on the same edge: overrun wins
      go_to(0);
      sum_i = 22'h000444;
      go_to(4);
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      chk("clr_vs_ovr", 32'(ovr_o), 32'd1);

      // mid-frame mask write takes effect at the next frame start
      go_to(2);
      cfg_we_i  = 1'b1;
      cfg_dat_i = 4'h5;
      tick();
      cfg_we_i = 1'b0;
      chk("mask_frozen", 32'(outctrl_o), 32'h0000000F);
      go_to(FL);
      tick();
      chk("mask_new_frame", 32'(outctrl_o), 32'h00000005);

      // randomized run: data, handshake, mask writes, occasional clears
      for (int i = 0; i < 6 * (FL + 1); i++) begin
         sum_i     = 22'($urandom());
         smp_rdy_i = 1'($urandom_range(0, 1));
         cfg_we_i  = ($urandom_range(0, 7) == 0);
         cfg_dat_i = 4'($urandom());
         ovr_clr_i = ($urandom_range(0, 15) == 0);
         tick();
      end
      cfg_we_i  = 1'b0;
      ovr_clr_i = 1'b0;
      smp_rdy_i = 1'b0;

      // stop request mid-frame: frame completes, then idle
      go_to(40);
      en_i = 1'b0;
      for (int i = 0; i < FL + 30; i++) begin
         sum_i     = 22'($urandom());
         smp_rdy_i = 1'($urandom_range(0, 1));
         tick();
      end
      chk("stop_idle", 32'(busy_o), 32'd0);
      en_i = 1'b1;
      tick();
      chk("restart_cnt", 32'(cnt_o), 32'd0);
      chk("restart_busy", 32'(busy_o), 32'd1);

      // overrun saturation: 300 frames with the buffer stalled
      smp_rdy_i = 1'b0;
      for (int i = 0; i < 300 * (FL + 1); i++) begin
         sum_i = 22'($urandom());
         tick();
      end
`ifdef PSG_SEQ_OVRCNT_EN
      chk("ovr_cnt_sat", 32'(ovr_cnt_o), 32'd255);
`else
      chk("ovr_cnt_tied", 32'(ovr_cnt_o), 32'd0);
`endif

      // mid-frame asynchronous reset with a sample held
      go_to(3);
      chk("pre_rst_vld", 32'(smp_vld_o), 32'd1);
      rst_i = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst_i = 1'b0;
      en_i  = 1'b0;
      tick();
      chk("post_rst_idle", 32'(busy_o), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psg_frame_sequencer.md
# psg_frame_sequencer

Frame sequencer for the PSG output path. It generates the select count that drives the channel summer and its channel mux, and double-buffers the channel output-enable mask so a mask never changes mid-frame. It captures the summed 22-bit result once per frame and presents it to the downstream filter/DAC stage through a one-entry valid/ready buffer, with overrun detection.

## Interface
- `FRAME_LAST`, default `8'd255`: last count value of a frame. Frame length is FRAME_LAST+1 clocks. Legal range is 8'd5..8'd255.

- `clk_i` in 1: master clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: run request. Sampled at idle and at frame end only.
- `cfg_we_i` in 1: output-mask write strobe.
- `cfg_dat_i` in 4: new output-enable mask, bit n = channel n.
- `cnt_o` out 8: select count to the summer.
- `ch_sel_o` out 2: channel-mux select, equal to `cnt_o[1:0]`.
- `outctrl_o` out 4: active output-enable mask to the summer.
- `sum_i` in 22: summed output from the summer.
- `smp_o` out 22: captured frame sample.
- `smp_vld_o` out 1: sample valid.
- `smp_rdy_i` in 1: downstream accepts. A transfer occurs when vld and rdy are both high at a clock edge.
- `ovr_o` out 1: sticky overrun flag.
- `ovr_clr_i` in 1: clears `ovr_o`.
- `ovr_cnt_o` out 8: overrun count. Tied to 0 without `PSG_SEQ_OVRCNT_EN`.
- `busy_o` out 1: high while in RUN.

## Operation
- **Reset values.** All outputs are 0, the pending mask is 0, and the FSM is in IDLE.
- **FSM: IDLE.**
  - `cnt_o` is held at 0 and `busy_o` is 0.
  - An edge with `en_i`=1 moves to RUN with `cnt_o` staying 0; that cycle is count 0 of the first frame.
- **FSM: RUN.**
  - `cnt_o` increments by 1 every clock.
  - At `cnt_o`==FRAME_LAST, `cnt_o` wraps to 0 on the next edge.
  - If `en_i`=0 at that wrap edge, the FSM goes to IDLE; otherwise it stays in RUN.
  - `en_i` is ignored mid-frame, so every frame always runs to completion.
- **Mask double-buffering.**
  - Pending mask next value = `cfg_we_i ? cfg_dat_i : pend`.
  - `outctrl_o` loads the pending next value (write bypass included) on:
    - every edge while in IDLE;
    - the IDLE→RUN edge;
    - every RUN wrap edge.
  - At all other times `outctrl_o` is frozen.
- **Capture.**
  - The summer accumulates during counts 0..3, so `sum_i` is final and stable during count 4.
  - Capture happens on the edge that ends a RUN cycle with `cnt_o`==4.
- **Capture-edge outcome:**
  - buffer empty (`smp_vld_o`=0): `smp_o` ← `sum_i`, `smp_vld_o` ← 1.
  - buffer full and `smp_rdy_i`=1: the old sample transfers, then `smp_o` ← `sum_i` and `smp_vld_o` stays 1. No overrun.
  - buffer full and `smp_rdy_i`=0: the new sample is dropped, the old `smp_o` is kept, and `ovr_o` ← 1. The counter increments under the macro.
- **Non-capture edges.** A transfer (vld and rdy both high) clears `smp_vld_o`. `smp_o` holds its value.
- **Overrun flag.** `ovr_clr_i` clears `ovr_o`. If a clear and a new overrun occur on the same edge, the overrun wins and `ovr_o`=1.
- **Async reset.** Mid-frame reset immediately forces all outputs to their reset values. A sample being held is discarded.

## Timing
- Capture latency: `smp_vld_o` rises in the cycle where `cnt_o`==5, one clock after `sum_i` is final.
- Throughput: one sample per FRAME_LAST+1 clocks (256 at default).
- The mask takes effect at count 0 of the frame following the write, or one clock after the write while in IDLE.
- `ch_sel_o` and `cnt_o` are registered and change only on `clk_i` edges.
- `smp_rdy_i` may be asserted at any time. There is no combinational path from `smp_rdy_i` to any output.

## Configuration
- `PSG_SEQ_OVRCNT_EN` defined: `ovr_cnt_o` is an 8-bit counter.
  - Increments on every dropped sample.
  - Saturates at 8'd255.
  - Cleared only by `rst_i`; `ovr_clr_i` does not affect it.
- Undefined: the counter is not built and `ovr_cnt_o` = 8'd0. All other behaviour is identical.

## Test plan
- **Basic capture.** Reset, then `en_i`=1, `cfg_dat_i`=4'hF with a write in IDLE, `sum_i`=22'h00ABCD from count 4, `smp_rdy_i`=0 → `outctrl_o`=4'hF at frame start, `smp_o`=22'h00ABCD with vld high at `cnt_o`=5. Raise rdy → vld low the next clock.
- **Overrun.** rdy=0 for 2 frames, with sums 22'h000111 then 22'h000222 → `smp_o` stays 22'h000111, `ovr_o`=1, `ovr_cnt_o`=1 (macro on) or 0 (macro off). Pulse `ovr_clr_i` → `ovr_o`=0 and the count is unchanged. After 300 overruns the count reads 255.
- **Simultaneous transfer and capture.** vld=1 holding 22'h000111, rdy=1 exactly on the count-4 edge with `sum_i`=22'h000222 → `smp_o`=22'h000222, vld stays 1, `ovr_o`=0.
- **Mid-frame mask write.** Write 4'h5 at `cnt_o`=2 → `outctrl_o` keeps its old value through count 255, and equals 4'h5 at the following count 0.
- **Stop request.** Drop `en_i` at `cnt_o`=100 → counting continues to 255, wraps to 0, enters IDLE, `busy_o`=0. No further captures with `sum_i` changing. Reasserting `en_i` restarts at count 0.
- **Mid-frame reset.** Assert `rst_i` at `cnt_o`=3 with vld=1 → all outputs read 0 before the next clock edge. After release, the FSM is in IDLE.
